// File: rtl/msync_gen_if.sv
// msync_gen_if: configuration, wheel/sync inputs and status outputs of msync_gen.
// The master modport drives the controls; the slave modport is the generator.
interface msync_gen_if;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] period;
  logic [7:0]  step_div;
  logic [15:0] holdoff;
  logic        adp;
  logic        bdp;
  logic        sync;
  logic        msync_n;
  logic [1:0]  trig_src;
  logic [31:0] wheel_pos;
  logic        wheel_dir;
  logic [15:0] sync_cnt;
  logic [7:0]  miss_cnt;
  logic [7:0]  quad_err_cnt;

  modport master (
    output enable, mode, period, step_div, holdoff,
    output adp, bdp, sync,
    input  msync_n, trig_src, wheel_pos, wheel_dir,
    input  sync_cnt, miss_cnt, quad_err_cnt
  );

  modport slave (
    input  enable, mode, period, step_div, holdoff,
    input  adp, bdp, sync,
    output msync_n, trig_src, wheel_pos, wheel_dir,
    output sync_cnt, miss_cnt, quad_err_cnt
  );
endinterface

// File: rtl/msync_gen.sv
// msync_gen: master sync generator (timer, wheel quadrature or external trigger).
// Define MSYNC_FILT_EN to add a FILT_LEN-cycle glitch filter on adp/bdp/sync.
module msync_gen #(
  parameter int unsigned PULSE_W  = 4,
  parameter int unsigned FILT_LEN = 4,
  parameter bit          EXT_POL  = 1'b1
) (
  input  logic       clk20,
  input  logic       res_n,
  msync_gen_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_HOLD
  } state_e;

  localparam logic [1:0] M_TIMER = 2'b00;
  localparam logic [1:0] M_WHEEL = 2'b01;
  localparam logic [1:0] M_EXT   = 2'b10;

  if (PULSE_W < 2 || FILT_LEN < 1 || FILT_LEN > 256) begin : g_param_chk
    $error("msync_gen: bad parameter");
  end

  // bit order {sync, bdp, adp}
  logic [2:0] s1_q;
  logic [2:0] s2_q;
  logic [2:0] in_f;
  logic [2:0] prev_q;

  always_ff @(posedge clk20) begin
    if (!res_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {bus.sync, bus.bdp, bus.adp};
      s2_q <= s1_q;
    end
  end

`ifdef MSYNC_FILT_EN
  logic [2:0]      flt_q;
  logic [2:0][7:0] fcnt_q;

  always_ff @(posedge clk20) begin
    if (!res_n) begin
      flt_q  <= '0;
      fcnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2_q[i] == flt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == 8'(FILT_LEN - 1)) begin
          flt_q[i]  <= s2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign in_f = flt_q;
`else
  assign in_f = s2_q;
`endif

  logic [1:0] ab_cur;
  logic [1:0] ab_prev;
  logic       step_fwd;
  logic       step_rev;
  logic       step_err;
  logic       ext_edge;

  assign ab_cur  = {in_f[0], in_f[1]};
  assign ab_prev = {prev_q[0], prev_q[1]};

  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    step_err = 1'b0;
    unique case ({ab_prev, ab_cur})
      4'b0001, 4'b0111,
      4'b1110, 4'b1000: step_fwd = 1'b1;
      4'b0100, 4'b1101,
      4'b1011, 4'b0010: step_rev = 1'b1;
      4'b0011, 4'b1100,
      4'b0110, 4'b1001: step_err = 1'b1;
      default: ;
    endcase
  end

  assign ext_edge = EXT_POL ? (in_f[2] & ~prev_q[2])
                            : (~in_f[2] & prev_q[2]);

  logic [1:0]         mode_q;
  logic               clr;
  logic [23:0]        timer_q;
  logic [23:0]        timer_d;
  logic               tmr_hit;
  logic signed [15:0] acc_q;
  logic signed [15:0] acc_d;
  logic               whl_hit;
  logic               ext_edge_q;
  logic [31:0]        pos_q;
  logic               dir_q;
  logic [7:0]         qerr_q;

  assign clr = (bus.mode != mode_q) | ~bus.enable;

  assign tmr_hit = (bus.period != '0) &&
                   (timer_q == bus.period - 24'd1);

  assign whl_hit = (bus.mode == M_WHEEL) &&
                   (bus.step_div != '0) &&
                   (acc_q >= $signed({8'h00, bus.step_div}));

  always_comb begin
    timer_d = timer_q + 24'd1;
    if (clr || bus.period == '0 ||
        timer_q >= bus.period - 24'd1) begin
      timer_d = '0;
    end
  end

  // accumulator saturates both ways so long reversals cannot wrap
  always_comb begin
    acc_d = acc_q;
    if (step_fwd && acc_q != 16'sh7fff) begin
      acc_d = acc_q + 16'sd1;
    end else if (step_rev && acc_q != 16'sh8000) begin
      acc_d = acc_q - 16'sd1;
    end
    if (clr || whl_hit) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk20) begin
    if (!res_n) begin
      prev_q     <= '0;
      ext_edge_q <= 1'b0;
      mode_q     <= '0;
      timer_q    <= '0;
      acc_q      <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      qerr_q     <= '0;
    end else begin
      prev_q     <= in_f;
      ext_edge_q <= ext_edge;
      mode_q     <= bus.mode;
      timer_q    <= timer_d;
      acc_q      <= acc_d;
      if (step_fwd) begin
        pos_q <= pos_q + 32'd1;
        dir_q <= 1'b1;
      end else if (step_rev) begin
        pos_q <= pos_q - 32'd1;
        dir_q <= 1'b0;
      end
      if (step_err && qerr_q != 8'hff) begin
        qerr_q <= qerr_q + 8'd1;
      end
    end
  end

  logic        sel_trig;
  logic        trig;
  state_e      state_q;
  state_e      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] sync_cnt_q;
  logic [15:0] sync_cnt_d;
  logic [7:0]  miss_q;
  logic [7:0]  miss_d;
  logic [1:0]  src_q;
  logic [1:0]  src_d;
  logic        msync_n_q;

  always_comb begin
    sel_trig = 1'b0;
    unique case (bus.mode)
      M_TIMER: sel_trig = tmr_hit;
      M_WHEEL: sel_trig = whl_hit;
      M_EXT:   sel_trig = ext_edge_q;
      default: sel_trig = 1'b0;
    endcase
  end

  assign trig = sel_trig & bus.enable;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    sync_cnt_d = sync_cnt_q;
    miss_d     = miss_q;
    src_d      = src_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (trig) begin
          state_d    = S_PULSE;
          sync_cnt_d = sync_cnt_q + 16'd1;
          src_d      = bus.mode;
        end
      end
      S_PULSE: begin
        if (cnt_q == 16'(PULSE_W - 1)) begin
          cnt_d   = '0;
          state_d = (bus.holdoff != '0) ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (bus.holdoff == '0 ||
            cnt_q >= bus.holdoff - 16'd1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (trig && state_q != S_IDLE && miss_q != 8'hff) begin
      miss_d = miss_q + 8'd1;
    end
    if (!bus.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk20) begin
    if (!res_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sync_cnt_q <= '0;
      miss_q     <= '0;
      src_q      <= '0;
      msync_n_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_cnt_q <= sync_cnt_d;
      miss_q     <= miss_d;
      src_q      <= src_d;
      msync_n_q  <= (state_d != S_PULSE);
    end
  end

  assign bus.msync_n      = msync_n_q;
  assign bus.trig_src     = src_q;
  assign bus.wheel_pos    = pos_q;
  assign bus.wheel_dir    = dir_q;
  assign bus.sync_cnt     = sync_cnt_q;
  assign bus.miss_cnt     = miss_q;
  assign bus.quad_err_cnt = qerr_q;
endmodule
